multi_dataflow_addressgen: RTL and testbench

- Per-stream address generator, directly downstream of the accelerator control block.
- Consumes one stream's address-generator job fields (trans_size, line_stride, line_length, feat_stride, feat_length, feat_roll, step, loop_outer) plus a base address.
- Emits a valid/ready sequence of word addresses toward the streamer's TCDM source/sink port.
- One instance per stream (in1, in2, out_r); the FSM pulses start at job launch.

---
 rtl/multi_dataflow_addressgen.sv | 165 ++++++++++++++++
 tb/tb_multi_dataflow_addressgen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dataflow_addressgen.sv
// Per-stream address generator: walks a word/line/feature/outer loop nest from a
// base address and emits one word address per accepted valid/ready handshake.
module multi_dataflow_addressgen #(
  parameter int ADDR_WIDTH   = 32,
  parameter int TRANS_WIDTH  = 32,
  parameter int STRIDE_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [TRANS_WIDTH-1:0]  trans_size_i,
  input  logic [STRIDE_WIDTH-1:0] line_stride_i,
  input  logic [STRIDE_WIDTH-1:0] line_length_i,
  input  logic [STRIDE_WIDTH-1:0] feat_stride_i,
  input  logic [STRIDE_WIDTH-1:0] feat_length_i,
  input  logic [STRIDE_WIDTH-1:0] feat_roll_i,
  input  logic [STRIDE_WIDTH-1:0] step_i,
  input  logic                    loop_outer_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    addr_valid_o,
  input  logic                    addr_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   base_q;
  logic [TRANS_WIDTH-1:0]  trans_q;
  logic [STRIDE_WIDTH-1:0] line_stride_q, line_len_q, feat_stride_q;
  logic [STRIDE_WIDTH-1:0] feat_len_q, feat_roll_q, step_q;
  logic                    loop_outer_q;

  logic [TRANS_WIDTH-1:0]  emit_cnt_q, emit_cnt_nxt;
  logic [STRIDE_WIDTH-1:0] word_cnt_q, line_cnt_q, feat_cnt_q;
  logic [STRIDE_WIDTH-1:0] word_cnt_nxt, line_cnt_nxt, feat_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   word_off_q, line_off_q, feat_off_q, outer_off_q;
  logic [ADDR_WIDTH-1:0]   step_ext, line_stride_ext, feat_stride_ext;

  logic start_ok, xfer, last_xfer;
  logic word_wrap, line_wrap, roll_wrap;

  assign start_ok  = (state_q == IDLE) && start_i;
  assign xfer      = addr_valid_o && addr_ready_i;
  assign emit_cnt_nxt = emit_cnt_q + 1'b1;
  assign last_xfer = xfer && (emit_cnt_nxt == trans_q);

  assign word_cnt_nxt = word_cnt_q + 1'b1;
  assign line_cnt_nxt = line_cnt_q + 1'b1;
  assign feat_cnt_nxt = feat_cnt_q + 1'b1;

  // Each wrap level only fires when every inner level wraps on the same transfer.
  assign word_wrap = (word_cnt_nxt == line_len_q);
  assign line_wrap = word_wrap && (line_cnt_nxt == feat_len_q);
  assign roll_wrap = line_wrap && (feat_roll_q != '0) && (feat_cnt_nxt == feat_roll_q);

  assign step_ext        = ADDR_WIDTH'(step_q);
  assign line_stride_ext = ADDR_WIDTH'(line_stride_q);
  assign feat_stride_ext = ADDR_WIDTH'(feat_stride_q);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (trans_size_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_xfer) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      base_q        <= '0;
      trans_q       <= '0;
      line_stride_q <= '0;
      line_len_q    <= '0;
      feat_stride_q <= '0;
      feat_len_q    <= '0;
      feat_roll_q   <= '0;
      step_q        <= '0;
      loop_outer_q  <= 1'b0;
      emit_cnt_q    <= '0;
      word_cnt_q    <= '0;
      line_cnt_q    <= '0;
      feat_cnt_q    <= '0;
      word_off_q    <= '0;
      line_off_q    <= '0;
      feat_off_q    <= '0;
      outer_off_q   <= '0;
    end else if (start_ok) begin
      base_q        <= base_addr_i;
      trans_q       <= trans_size_i;
      line_stride_q <= line_stride_i;
      line_len_q    <= (line_length_i == '0) ? STRIDE_WIDTH'(1) : line_length_i;
      feat_stride_q <= feat_stride_i;
      feat_len_q    <= (feat_length_i == '0) ? STRIDE_WIDTH'(1) : feat_length_i;
      feat_roll_q   <= feat_roll_i;
      step_q        <= step_i;
      loop_outer_q  <= loop_outer_i;
      emit_cnt_q    <= '0;
      word_cnt_q    <= '0;
      line_cnt_q    <= '0;
      feat_cnt_q    <= '0;
      word_off_q    <= '0;
      line_off_q    <= '0;
      feat_off_q    <= '0;
      outer_off_q   <= '0;
    end else if (xfer) begin
      // Advancing past the final transfer is harmless: the next start zeroes it all.
      emit_cnt_q <= emit_cnt_nxt;
      if (word_wrap) begin
        word_cnt_q <= '0;
        word_off_q <= '0;
        if (line_wrap) begin
          line_cnt_q <= '0;
          line_off_q <= '0;
          if (roll_wrap) begin
            feat_cnt_q <= '0;
            feat_off_q <= '0;
            if (loop_outer_q) begin
              outer_off_q <= outer_off_q + line_stride_ext;
            end
          end else begin
            feat_cnt_q <= feat_cnt_nxt;
            feat_off_q <= feat_off_q + feat_stride_ext;
          end
        end else begin
          line_cnt_q <= line_cnt_nxt;
          line_off_q <= line_off_q + line_stride_ext;
        end
      end else begin
        word_cnt_q <= word_cnt_nxt;
        word_off_q <= word_off_q + step_ext;
      end
    end
  end

  assign addr_valid_o = (state_q == RUN);
  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign addr_o       = (state_q == RUN)
                      ? (base_q + outer_off_q + feat_off_q + line_off_q + word_off_q)
                      : '0;

endmodule

// File: tb/tb_multi_dataflow_addressgen.sv
// Randomised and directed bench for multi_dataflow_addressgen; expected address
// streams come from a closed-form index-decomposition model of the loop nest.
module tb_multi_dataflow_addressgen;

  logic        clk = 1'b0;
  logic        rst_i, clear_i, start_i;
  logic [31:0] base_addr_i, trans_size_i;
  logic [15:0] line_stride_i, line_length_i, feat_stride_i;
  logic [15:0] feat_length_i, feat_roll_i, step_i;
  logic        loop_outer_i;
  logic [31:0] addr_o;
  logic        addr_valid_o, addr_ready_i, busy_o, done_o;

  always #5 clk = ~clk;

  multi_dataflow_addressgen #(
    .ADDR_WIDTH(32), .TRANS_WIDTH(32), .STRIDE_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .trans_size_i(trans_size_i),
    .line_stride_i(line_stride_i), .line_length_i(line_length_i),
    .feat_stride_i(feat_stride_i), .feat_length_i(feat_length_i),
    .feat_roll_i(feat_roll_i), .step_i(step_i), .loop_outer_i(loop_outer_i),
    .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  int checks = 0;
  int passed = 0;

  logic [31:0] c_base, c_trans;
  logic [15:0] c_ls, c_ll, c_fs, c_fl, c_fr, c_st;
  logic        c_lo;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int done_cyc, busy_cnt, stall_err, post_err, timed_out;

  // Address i decomposes into word/line/feature/roll indices by division.
  function automatic void build_expected();
    longint unsigned len_w, len_l, fi, w, l, f, o, a;
    exp_q.delete();
    len_w = (c_ll == 0) ? 1 : longint'(c_ll);
    len_l = (c_fl == 0) ? 1 : longint'(c_fl);
    for (longint unsigned i = 0; i < longint'(c_trans); i++) begin
      w  = i % len_w;
      l  = (i / len_w) % len_l;
      fi = i / (len_w * len_l);
      if (c_fr != 0) begin
        f = fi % longint'(c_fr);
        o = fi / longint'(c_fr);
      end else begin
        f = fi;
        o = 0;
      end
      a = longint'(c_base) + (c_lo ? o * longint'(c_ls) : 0) + f * longint'(c_fs)
        + l * longint'(c_ls) + w * longint'(c_st);
      exp_q.push_back(a[31:0]);
    end
  endfunction

  task automatic set_nested();
    c_base = 32'h1000; c_st = 16'd4; c_ll = 16'd2; c_ls = 16'h100;
    c_fl = 16'd2; c_fs = 16'h1000; c_fr = 16'd0; c_trans = 32'd6; c_lo = 1'b0;
  endtask

  task automatic drive_garbage();
    base_addr_i   = $urandom;
    trans_size_i  = $urandom | 32'd1;
    line_stride_i = 16'($urandom);
    line_length_i = 16'($urandom);
    feat_stride_i = 16'($urandom);
    feat_length_i = 16'($urandom);
    feat_roll_i   = 16'($urandom);
    step_i        = 16'($urandom);
    loop_outer_i  = 1'($urandom);
  endtask

  // Launches the current config and records accepted addresses and timing.
  task automatic run_job(input int ready_mode, input int restart_at, input int max_cycles);
    int cyc;
    logic prev_stall;
    logic [31:0] prev_addr;
    obs_q.delete();
    done_cyc = -1; busy_cnt = 0; stall_err = 0; post_err = 0; timed_out = 0;
    base_addr_i = c_base; trans_size_i = c_trans; line_stride_i = c_ls;
    line_length_i = c_ll; feat_stride_i = c_fs; feat_length_i = c_fl;
    feat_roll_i = c_fr; step_i = c_st; loop_outer_i = c_lo;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    drive_garbage();
    prev_stall = 1'b0; prev_addr = '0; cyc = 0;
    while (done_cyc < 0 && cyc < max_cycles) begin
      case (ready_mode)
        0:       addr_ready_i = 1'b1;
        1:       addr_ready_i = (cyc % 3 == 0);
        default: addr_ready_i = 1'($urandom_range(0, 1));
      endcase
      start_i = (cyc == restart_at);
      if (prev_stall && addr_o !== prev_addr) stall_err++;
      if (busy_o) busy_cnt++;
      if (done_o) done_cyc = cyc;
      if (addr_valid_o && addr_ready_i) obs_q.push_back(addr_o);
      prev_stall = addr_valid_o && !addr_ready_i;
      prev_addr  = addr_o;
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc++;
    end
    if (done_cyc < 0) timed_out = 1;
    for (int k = 0; k < 3; k++) begin
      if (addr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) post_err++;
      @(posedge clk); #1;
    end
    addr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; addr_ready_i = 1'b0;
    drive_garbage();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (addr_o !== 32'h0) $display("[TB] FAIL reset addr_o: got %h expected 0", addr_o); else passed++;
    checks++; if (addr_valid_o !== 1'b0) $display("[TB] FAIL reset valid: got %b expected 0", addr_valid_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("[TB] FAIL reset busy: got %b expected 0", busy_o); else passed++;
    checks++; if (done_o !== 1'b0) $display("[TB] FAIL reset done: got %b expected 0", done_o); else passed++;
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({addr_o, addr_valid_o, busy_o, done_o} !== 35'h0)
        $display("[TB] FAIL idle cycle %0d: got addr=%h v=%b b=%b d=%b expected all 0",
                 i, addr_o, addr_valid_o, busy_o, done_o);
      else passed++;
    end
  endtask

  task automatic test_nested();
    logic [31:0] ref_addr [6];
    ref_addr = '{32'h1000, 32'h1004, 32'h1100, 32'h1104, 32'h2000, 32'h2004};
    set_nested();
    run_job(0, -1, 100);
    checks++; if (obs_q.size() != 6) $display("[TB] FAIL nested count: got %0d expected 6", obs_q.size()); else passed++;
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== ref_addr[i]) $display("[TB] FAIL nested addr[%0d]: got %h expected %h", i, obs_q[i], ref_addr[i]);
      else passed++;
    end
    checks++; if (done_cyc != 6) $display("[TB] FAIL nested done cycle: got %0d expected 6", done_cyc); else passed++;
    checks++; if (busy_cnt != 6) $display("[TB] FAIL nested busy cycles: got %0d expected 6", busy_cnt); else passed++;
  endtask

  task automatic test_roll();
    logic [31:0] ref_on [4];
    logic [31:0] ref_off [4];
    ref_on  = '{32'h1000, 32'h1100, 32'h1010, 32'h1110};
    ref_off = '{32'h1000, 32'h1100, 32'h1000, 32'h1100};
    for (int pass = 0; pass < 2; pass++) begin
      c_base = 32'h1000; c_ll = 16'd1; c_fl = 16'd1; c_st = 16'd4; c_ls = 16'h10;
      c_fs = 16'h100; c_fr = 16'd2; c_trans = 32'd4; c_lo = (pass == 0);
      run_job(0, -1, 100);
      checks++; if (obs_q.size() != 4) $display("[TB] FAIL roll%0d count: got %0d expected 4", pass, obs_q.size()); else passed++;
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== (pass == 0 ? ref_on[i] : ref_off[i]))
          $display("[TB] FAIL roll%0d addr[%0d]: got %h expected %h", pass, i, obs_q[i],
                   pass == 0 ? ref_on[i] : ref_off[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    set_nested();
    build_expected();
    run_job(1, -1, 200);
    checks++; if (obs_q.size() != exp_q.size()) $display("[TB] FAIL bp count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL bp addr[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
    checks++; if (stall_err != 0) $display("[TB] FAIL bp stall hold: got %0d changes expected 0", stall_err); else passed++;
    checks++; if (done_cyc != 16) $display("[TB] FAIL bp done cycle: got %0d expected 16", done_cyc); else passed++;
  endtask

  task automatic test_zero_and_restart();
    set_nested();
    c_trans = 32'd0;
    run_job(0, -1, 50);
    checks++; if (obs_q.size() != 0) $display("[TB] FAIL zero count: got %0d expected 0", obs_q.size()); else passed++;
    checks++; if (done_cyc != 0) $display("[TB] FAIL zero done cycle: got %0d expected 0", done_cyc); else passed++;
    checks++; if (busy_cnt != 0) $display("[TB] FAIL zero busy: got %0d expected 0", busy_cnt); else passed++;
    for (int r = 0; r < 2; r++) begin
      set_nested();
      build_expected();
      run_job(0, (r == 0) ? 2 : 6, 100);
      checks++; if (obs_q.size() != exp_q.size()) $display("[TB] FAIL restart%0d count: got %0d expected %0d", r, obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL restart%0d addr[%0d]: got %h expected %h", r, i, obs_q[i], exp_q[i]);
        else passed++;
      end
      checks++; if (post_err != 0 || timed_out != 0) $display("[TB] FAIL restart%0d after done: got post=%0d timeout=%0d expected 0", r, post_err, timed_out); else passed++;
    end
  endtask

  task automatic test_clear();
    int seen_done;
    set_nested();
    build_expected();
    base_addr_i = c_base; trans_size_i = c_trans; line_stride_i = c_ls; line_length_i = c_ll;
    feat_stride_i = c_fs; feat_length_i = c_fl; feat_roll_i = c_fr; step_i = c_st; loop_outer_i = c_lo;
    start_i = 1'b1; addr_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    clear_i = 1'b1; addr_ready_i = 1'b0;
    @(posedge clk); #1;
    clear_i = 1'b0;
    checks++; if (addr_valid_o !== 1'b0 || busy_o !== 1'b0) $display("[TB] FAIL clear drop: got v=%b b=%b expected 0", addr_valid_o, busy_o); else passed++;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done_o) seen_done++;
      @(posedge clk); #1;
    end
    checks++; if (seen_done != 0) $display("[TB] FAIL clear done pulse: got %0d expected 0", seen_done); else passed++;
    run_job(0, -1, 100);
    checks++; if (obs_q.size() != exp_q.size()) $display("[TB] FAIL clear rerun count: got %0d expected %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL clear rerun addr[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) begin
      c_base  = (j % 3 == 0) ? 32'hFFFF_FF00 | $urandom_range(0, 255) : $urandom;
      c_trans = $urandom_range(0, 30);
      c_ll = 16'($urandom_range(0, 4));
      c_fl = 16'($urandom_range(0, 3));
      c_fr = 16'($urandom_range(0, 3));
      c_st = 16'($urandom_range(0, 255));
      c_ls = 16'($urandom);
      c_fs = 16'($urandom);
      c_lo = 1'($urandom);
      build_expected();
      run_job(2, -1, 1000);
      checks++; if (obs_q.size() != exp_q.size()) $display("[TB] FAIL rand%0d count: got %0d expected %0d", j, obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL rand%0d addr[%0d]: got %h expected %h", j, i, obs_q[i], exp_q[i]);
        else passed++;
      end
      checks++;
      if (timed_out != 0 || stall_err != 0 || busy_cnt != done_cyc)
        $display("[TB] FAIL rand%0d protocol: got timeout=%0d stall=%0d busy=%0d done_at=%0d expected 0/0/equal",
                 j, timed_out, stall_err, busy_cnt, done_cyc);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_nested();
    test_roll();
    test_backpressure();
    test_zero_and_restart();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
